// File: rtl/tpu_feeder_pkg.sv
// Shared constants, FSM state type and step-counter sizing for the A-operand feeder.
package tpu_feeder_pkg;

    localparam int FD_BITS = 8;
    localparam int FD_DIM  = 8;

    typedef enum logic {
        FD_IDLE = 1'b0,
        FD_FEED = 1'b1
    } feeder_state_t;

    // Steps run 0..2*dim-2, so the counter must hold 2*dim-1 distinct values.
    function automatic int step_width(input int dim);
        return $clog2(2 * dim - 1);
    endfunction

endpackage

// File: rtl/feeder_bank.sv
// DIMxDIM operand store: one row write port, combinational skewed-diagonal read at step t.
// Latency: write visible the cycle after wr_en; read is combinational from stored rows.
// Backpressure: none; caller gates wr_en.
module feeder_bank
    import tpu_feeder_pkg::*;
#(
    parameter int BITS = FD_BITS,
    parameter int DIM  = FD_DIM
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [$clog2(DIM)-1:0]       wr_row,
    input  logic [DIM*BITS-1:0]          wr_data,
    input  logic [step_width(DIM)-1:0]   step,
    output logic [DIM*BITS-1:0]          col_data
);

    localparam int RW = $clog2(DIM);

    logic [DIM*BITS-1:0] mem [DIM];

    // Row indices at or above DIM match no row, so those writes fall away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DIM; r++) begin
                mem[r] <= '0;
            end
        end else begin
            for (int r = 0; r < DIM; r++) begin
                if (wr_en && (wr_row == RW'(r))) begin
                    mem[r] <= wr_data;
                end
            end
        end
    end

    // Row r emits column t-r; rows with no element on this diagonal stay zero.
    always_comb begin
        col_data = '0;
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                if ((r + c) == int'(step)) begin
                    col_data[r*BITS +: BITS] = mem[r][c*BITS +: BITS];
                end
            end
        end
    end

endmodule

// File: rtl/systolic_a_feeder.sv
// Streams a stored DIMxDIM A matrix into the array left edge with per-row skew; FEEDER_PINGPONG_EN adds a shadow bank.
// Latency: first feed vector one cycle after start; 2*DIM-1 valid cycles per matrix.
// Backpressure: none; writes/starts while busy are dropped (single bank) or shadowed/queued one deep (ping-pong).
module systolic_a_feeder
    import tpu_feeder_pkg::*;
#(
    parameter int BITS = FD_BITS,
    parameter int DIM  = FD_DIM
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [$clog2(DIM)-1:0]  wr_row,
    input  logic [DIM*BITS-1:0]     wr_data,
    input  logic                    start,
    output logic                    busy,
    output logic                    feed_valid,
    output logic [DIM*BITS-1:0]     feed_data,
    output logic                    feed_done
);

    localparam int              SW   = step_width(DIM);
    localparam logic [SW-1:0]   LAST = SW'(2 * DIM - 2);

    feeder_state_t          state_q;
    feeder_state_t          state_d;
    logic [SW-1:0]          step_q;
    logic [SW-1:0]          step_d;
    logic                   last_step;
    logic                   go;
    logic                   fwd;
    logic [DIM*BITS-1:0]    rd_data;
    logic [DIM*BITS-1:0]    data_d;
    logic                   done_d;
    logic                   run_q;
    logic                   done_q;
    logic [DIM*BITS-1:0]    data_q;

    assign last_step = (state_q == FD_FEED) && (step_q == LAST);

`ifdef FEEDER_PINGPONG_EN
    logic                   bank_q;
    logic                   pend_q;
    logic                   pend_d;
    logic                   rd_sel;
    logic [DIM*BITS-1:0]    bank_rd [2];

    // A queued or coincident start chains the next matrix straight after the last step.
    assign go     = ((state_q == FD_IDLE) && start) || (last_step && (pend_q || start));
    assign rd_sel = go ? ~bank_q : bank_q;
    assign fwd    = go && wr_en && (wr_row == '0);

    for (genvar i = 0; i < 2; i++) begin : g_bank
        feeder_bank #(
            .BITS (BITS),
            .DIM  (DIM)
        ) u_bank (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (wr_en && (bank_q != 1'(i))),
            .wr_row   (wr_row),
            .wr_data  (wr_data),
            .step     (step_d),
            .col_data (bank_rd[i])
        );
    end

    assign rd_data = bank_rd[rd_sel];

    always_comb begin
        pend_d = pend_q;
        if (go) begin
            pend_d = 1'b0;
        end else if ((state_q == FD_FEED) && start) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            if (go) begin
                bank_q <= ~bank_q;
            end
        end
    end
`else
    logic wr_idle;

    assign go      = (state_q == FD_IDLE) && start;
    assign wr_idle = wr_en && (state_q == FD_IDLE);
    assign fwd     = go && wr_en && (wr_row == '0);

    feeder_bank #(
        .BITS (BITS),
        .DIM  (DIM)
    ) u_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_idle),
        .wr_row   (wr_row),
        .wr_data  (wr_data),
        .step     (step_d),
        .col_data (rd_data)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FD_IDLE;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = '0;
        case (state_q)
            FD_IDLE: begin
                if (go) begin
                    state_d = FD_FEED;
                end
            end
            FD_FEED: begin
                if (go) begin
                    step_d = '0;
                end else if (last_step) begin
                    state_d = FD_IDLE;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            default: state_d = FD_IDLE;
        endcase
    end

    // Step 0 only reads M[0][0]; a same-cycle row-0 write is forwarded so the feed sees it.
    always_comb begin
        data_d = '0;
        done_d = 1'b0;
        if (state_d == FD_FEED) begin
            data_d = rd_data;
            if (fwd) begin
                data_d[BITS-1:0] = wr_data[BITS-1:0];
            end
            done_d = (step_d == LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= 1'b0;
            done_q <= 1'b0;
            data_q <= '0;
        end else begin
            run_q  <= (state_d == FD_FEED);
            done_q <= done_d;
            data_q <= data_d;
        end
    end

    assign busy       = run_q;
    assign feed_valid = run_q;
    assign feed_done  = done_q;
    assign feed_data  = data_q;

endmodule
